// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler
//   Phase sequencer and round-robin request arbiter for a two-street
//   intersection (main street, side street, pedestrian crossing).
//   Main street rests on green. Side and pedestrian requests are latched
//   and served as timed phases. All durations are counted in tick strobes.
// Ports:
//   masterclk       system clock, rising edge
//   reset_button    asynchronous active-high reset
//   tick            timebase strobe, one masterclk cycle wide
//   sensor_button   side-street vehicle request (level)
//   ped_button      pedestrian request (level)
//   mainStreetleds  {red, yellow, green} for main street
//   sideStreetleds  {red, yellow, green} for side street
//   walk            pedestrian walk lamp
//   phase           current state encoding
module tlc_phase_scheduler #(
  parameter int T_MIN_GREEN  = 8,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 1,
  parameter int T_SIDE_GREEN = 5,
  parameter int T_WALK       = 6,
  parameter int TW           = 8
) (
  input  logic       masterclk,
  input  logic       reset_button,
  input  logic       tick,
  input  logic       sensor_button,
  input  logic       ped_button,
  output logic [2:0] mainStreetleds,
  output logic [2:0] sideStreetleds,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MG  = 3'd0, S_MY  = 3'd1, S_ARA = 3'd2, S_SG = 3'd3,
    S_SY  = 3'd4, S_PW  = 3'd5, S_PC  = 3'd6, S_ARB = 3'd7
  } state_t;

  // Exit thresholds: a state of duration T leaves on the tick where timer==T-1.
  localparam logic [TW-1:0] D_MING = TW'(T_MIN_GREEN - 1);
  localparam logic [TW-1:0] D_YEL  = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] D_AR   = TW'(T_ALL_RED - 1);
  localparam logic [TW-1:0] D_SG   = TW'(T_SIDE_GREEN - 1);
  localparam logic [TW-1:0] D_WALK = TW'(T_WALK - 1);

  localparam logic P_SIDE = 1'b0;
  localparam logic P_PED  = 1'b1;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          side_req, ped_req, prio;
  logic          chg, enter_sg, enter_pw;

  assign chg      = (state_next != state);
  assign enter_sg = chg && (state_next == S_SG);
  assign enter_pw = chg && (state_next == S_PW);

  // state register
  always_ff @(posedge masterclk or posedge reset_button) begin
    if (reset_button) state <= S_MG;
    else              state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_MG:  if (tick && timer >= D_MING && (side_req || ped_req)) state_next = S_MY;
      S_MY:  if (tick && timer == D_YEL) state_next = S_ARA;
      S_ARA: if (tick && timer == D_AR) begin
        // Both pending: prio breaks the tie; lone request is served directly.
        if (side_req && (!ped_req || prio == P_SIDE)) state_next = S_SG;
        else if (ped_req)                              state_next = S_PW;
        else                                           state_next = S_MG;
      end
      S_SG:  if (tick && timer == D_SG)   state_next = S_SY;
      S_SY:  if (tick && timer == D_YEL)  state_next = S_ARB;
      S_PW:  if (tick && timer == D_WALK) state_next = S_PC;
      S_PC:  if (tick && timer == D_YEL)  state_next = S_ARB;
      S_ARB: if (tick && timer == D_AR)   state_next = S_MG;
      default: state_next = S_MG;
    endcase
  end

  // phase timer, request latches and round-robin pointer
  always_ff @(posedge masterclk or posedge reset_button) begin
    if (reset_button) begin
      timer    <= '0;
      side_req <= 1'b0;
      ped_req  <= 1'b0;
      prio     <= P_SIDE;
    end else begin
      if (chg)                  timer <= '0;
      else if (tick && ~&timer) timer <= timer + 1'b1;

      // Clear wins over a press landing on the service-entry edge.
      if (enter_sg)                                          side_req <= 1'b0;
      else if (sensor_button && state != S_SG && state != S_SY) side_req <= 1'b1;

      if (enter_pw)                                          ped_req <= 1'b0;
      else if (ped_button && state != S_PW && state != S_PC) ped_req <= 1'b1;

      if (enter_sg)      prio <= P_PED;
      else if (enter_pw) prio <= P_SIDE;
    end
  end

  // output decode: state only, no input-to-output path
  always_comb begin
    mainStreetleds = 3'b100;
    sideStreetleds = 3'b100;
    walk           = 1'b0;
    case (state)
      S_MG: mainStreetleds = 3'b001;
      S_MY: mainStreetleds = 3'b010;
      S_SG: sideStreetleds = 3'b001;
      S_SY: sideStreetleds = 3'b010;
      S_PW: walk           = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler with default timing parameters.
// Inputs are driven and outputs sampled on the falling edge of masterclk.
module tb_tlc_phase_scheduler;

  logic       masterclk = 1'b0;
  logic       reset_button = 1'b0;
  logic       tick = 1'b1;
  logic       sensor_button = 1'b0;
  logic       ped_button = 1'b0;
  logic [2:0] mainStreetleds, sideStreetleds, phase;
  logic       walk;

  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;
  bit tick_div  = 1'b0;  // tick every 4th cycle
  bit tick_hold = 1'b0;  // tick forced low

  tlc_phase_scheduler dut (
    .masterclk     (masterclk),
    .reset_button  (reset_button),
    .tick          (tick),
    .sensor_button (sensor_button),
    .ped_button    (ped_button),
    .mainStreetleds(mainStreetleds),
    .sideStreetleds(sideStreetleds),
    .walk          (walk),
    .phase         (phase)
  );

  always #5 masterclk = ~masterclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {main, side, walk} for a phase.
  function automatic logic [6:0] dec(input logic [2:0] p);
    case (p)
      3'd0:    return {3'b001, 3'b100, 1'b0};
      3'd1:    return {3'b010, 3'b100, 1'b0};
      3'd3:    return {3'b100, 3'b001, 1'b0};
      3'd4:    return {3'b100, 3'b010, 1'b0};
      3'd5:    return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  // Advance to next falling edge, then drive tick for the coming cycle.
  task automatic cyc();
    @(negedge masterclk);
    ncyc++;
    tick = tick_hold ? 1'b0 : (tick_div ? (ncyc % 4 == 0) : 1'b1);
  endtask

  // Expect phase p (and its decoded lamps) for n consecutive samples.
  task automatic expect_phase(input string tag, input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_phase"}, {29'd0, phase}, {29'd0, p});
      chk({tag, "_lamps"}, {25'd0, mainStreetleds, sideStreetleds, walk}, {25'd0, dec(p)});
      chk({tag, "_safe"}, {31'd0, mainStreetleds[0] & sideStreetleds[0]}, 32'd0);
      cyc();
    end
  endtask

  // Wait (bounded) for phase p, then measure its length in cycles.
  task automatic measure(input string tag, input logic [2:0] p, input int want);
    int k = 0;
    int n = 0;
    while (phase != p && k < 500) begin cyc(); k++; end
    chk({tag, "_reach"}, {29'd0, phase}, {29'd0, p});
    while (phase == p && n < 500) begin n++; cyc(); end
    chk({tag, "_len"}, n, want);
  endtask

  task automatic do_reset();
    reset_button = 1'b1;
    #3;
    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_lamps", {25'd0, mainStreetleds, sideStreetleds, walk}, {25'd0, dec(3'd0)});
    cyc();
    reset_button = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1000000");
    $fatal(1);
  end

  initial begin
    cyc();

    // idle: no requests, main green holds
    do_reset();
    expect_phase("idle", 3'd0, 50);

    // side service, request latched right after reset
    do_reset();
    chk("side_p0", {29'd0, phase}, 32'd0);
    sensor_button = 1'b1; cyc(); sensor_button = 1'b0;
    expect_phase("side", 3'd0, 7);
    expect_phase("side", 3'd1, 3);
    expect_phase("side", 3'd2, 1);
    expect_phase("side", 3'd3, 5);
    expect_phase("side", 3'd4, 3);
    expect_phase("side", 3'd7, 1);
    expect_phase("side", 3'd0, 12);

    // pedestrian request after min green elapsed: exits on next tick
    do_reset();
    expect_phase("ped", 3'd0, 20);
    ped_button = 1'b1; cyc(); ped_button = 1'b0;
    expect_phase("ped", 3'd0, 1);
    expect_phase("ped", 3'd1, 3);
    expect_phase("ped", 3'd2, 1);
    expect_phase("ped", 3'd5, 6);
    expect_phase("ped", 3'd6, 3);
    expect_phase("ped", 3'd7, 1);
    expect_phase("ped", 3'd0, 12);

    // arbitration: both held from reset, side first then alternate
    sensor_button = 1'b1; ped_button = 1'b1;
    do_reset();
    expect_phase("arb", 3'd0, 8);
    expect_phase("arb", 3'd1, 3);
    expect_phase("arb", 3'd2, 1);
    expect_phase("arb", 3'd3, 5);
    expect_phase("arb", 3'd4, 3);
    expect_phase("arb", 3'd7, 1);
    expect_phase("arb", 3'd0, 8);
    expect_phase("arb", 3'd1, 3);
    expect_phase("arb", 3'd2, 1);
    expect_phase("arb", 3'd5, 6);
    expect_phase("arb", 3'd6, 3);
    expect_phase("arb", 3'd7, 1);
    expect_phase("arb", 3'd0, 8);
    expect_phase("arb", 3'd1, 3);
    expect_phase("arb", 3'd2, 1);
    expect_phase("arb", 3'd3, 5);
    sensor_button = 1'b0; ped_button = 1'b0;

    // long idle: timer saturates rather than wrapping
    do_reset();
    expect_phase("sat", 3'd0, 300);
    sensor_button = 1'b1; cyc(); sensor_button = 1'b0;
    expect_phase("sat", 3'd0, 1);
    expect_phase("sat", 3'd1, 3);

    // tick every 4th cycle: each phase lasts 4x its tick count
    tick_div = 1'b1;
    do_reset();
    sensor_button = 1'b1; cyc(); sensor_button = 1'b0;
    measure("tb_my",  3'd1, 12);
    measure("tb_ara", 3'd2, 4);
    measure("tb_sg",  3'd3, 20);
    measure("tb_sy",  3'd4, 12);
    measure("tb_arb", 3'd7, 4);

    // tick held low mid main-yellow freezes the phase
    sensor_button = 1'b1; cyc(); sensor_button = 1'b0;
    begin
      int k = 0;
      while (phase != 3'd1 && k < 200) begin cyc(); k++; end
    end
    chk("frz_enter", {29'd0, phase}, 32'd1);
    tick_hold = 1'b1;
    expect_phase("frz", 3'd1, 25);
    tick_hold = 1'b0; tick_div = 1'b0;
    begin
      int k = 0;
      while (phase != 3'd2 && k < 10) begin cyc(); k++; end
    end
    chk("frz_resume", {29'd0, phase}, 32'd2);

    // asynchronous reset mid side-green with a pending ped request
    do_reset();
    sensor_button = 1'b1; cyc(); sensor_button = 1'b0;
    begin
      int k = 0;
      while (phase != 3'd3 && k < 100) begin cyc(); k++; end
    end
    chk("amid_sg", {29'd0, phase}, 32'd3);
    ped_button = 1'b1; cyc(); ped_button = 1'b0;
    cyc();
    #2 reset_button = 1'b1;
    #1;
    chk("amid_phase", {29'd0, phase}, 32'd0);
    chk("amid_lamps", {25'd0, mainStreetleds, sideStreetleds, walk}, {25'd0, dec(3'd0)});
    cyc();
    reset_button = 1'b0;
    expect_phase("amid_idle", 3'd0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
- Phase sequencer and request arbiter for the two-street intersection: main street, side street and a pedestrian crossing.
- Main street rests on green. Side-street vehicle requests (sensor_button) and pedestrian requests (ped_button) are latched, arbitrated round-robin and served as timed phases.
- Drives the main/side R-Y-G LED buses directly. All timing is counted in units of an external one-cycle tick strobe, so the same RTL serves both 1 Hz board operation and fast simulation.

Parameters:
T_MIN_GREEN, 8, minimum main-green duration in ticks (>=1)
T_YELLOW, 3, yellow and pedestrian-clearance duration in ticks (>=1)
T_ALL_RED, 1, all-red interval in ticks (>=1)
T_SIDE_GREEN, 5, side-green duration in ticks (>=1)
T_WALK, 6, pedestrian walk duration in ticks (>=1)
TW, 8, timer width; every T_* must be <= 2^TW-1

Ports:
masterclk  input  1  system clock, rising-edge
reset_button  input  1  asynchronous active-high reset
tick  input  1  timebase strobe, one masterclk cycle wide
sensor_button  input  1  side-street vehicle request, level, synchronous to masterclk
ped_button  input  1  pedestrian request, level, synchronous to masterclk
mainStreetleds  output  3  {red, yellow, green}
sideStreetleds  output  3  {red, yellow, green}
walk  output  1  pedestrian walk lamp
phase  output  3  current state encoding (debug/verification)

Behaviour:
- Clock and reset: one clock, masterclk. reset_button is asynchronous and active-high.
- States and phase encoding: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, SIDE_GREEN=3, SIDE_YELLOW=4, PED_WALK=5, PED_CLEAR=6, ALL_RED_B=7.
- Outputs are a pure decode of the state register; there is no combinational path from any input to any output.
  - MAIN_GREEN: main=001, side=100
  - MAIN_YELLOW: main=010, side=100
  - SIDE_GREEN: main=100, side=001
  - SIDE_YELLOW: main=100, side=010
  - All other states: main=100, side=100
  - walk=1 only in PED_WALK.
- Reset (asynchronous, overrides everything, may occur in any state):
  - state=MAIN_GREEN, timer=0, side_req=0, ped_req=0, prio=SIDE.
  - Therefore main=001, side=100, walk=0, phase=0 immediately.
- Timer:
  - Cleared to 0 on every state change.
  - Increments on tick cycles, saturating at 2^TW-1.
  - A timed state of duration T exits on the tick cycle where timer==T-1, so it lasts exactly T ticks.
  - The state changes at the clock edge of that tick cycle.
- Request latches:
  - side_req is set on any cycle with sensor_button=1, except while in SIDE_GREEN or SIDE_YELLOW.
  - ped_req is set on any cycle with ped_button=1, except while in PED_WALK or PED_CLEAR.
  - Each latch is cleared on the edge that enters its service phase (SIDE_GREEN or PED_WALK).
  - A press on the same edge as the clear is ignored.
- Transitions:
  - MAIN_GREEN -> MAIN_YELLOW: on a tick cycle with timer>=T_MIN_GREEN-1 and (side_req or ped_req). If a request arrives after the minimum green has elapsed, exit on the next tick.
  - MAIN_YELLOW -> ALL_RED_A after T_YELLOW ticks.
  - ALL_RED_A exits after T_ALL_RED ticks, chosen as follows:
    - Both pending: SIDE_GREEN if prio=SIDE, else PED_WALK.
    - Only one pending: serve that one.
    - Neither pending (not reachable in normal operation): MAIN_GREEN.
  - SIDE_GREEN -> SIDE_YELLOW after T_SIDE_GREEN ticks, then -> ALL_RED_B after T_YELLOW ticks.
  - PED_WALK -> PED_CLEAR after T_WALK ticks, then -> ALL_RED_B after T_YELLOW ticks.
  - ALL_RED_B -> MAIN_GREEN after T_ALL_RED ticks.
  - Main street always regains at least T_MIN_GREEN between services, so a second pending request waits for the next cycle.
- Round-robin priority: on entering SIDE_GREEN, prio:=PED; on entering PED_WALK, prio:=SIDE.
- tick=0 freezes the timer and all timed exits. The request latches still sample on every clock.
- Safety invariant: mainStreetleds[0] and sideStreetleds[0] are never both 1. Each bus is always one-hot.

Test Plan:
- Idle: reset pulse, tick=1 continuous, no requests for 50 cycles -> phase stays 0, main=001, side=100, walk=0.
- Side service: reset, tick=1, sensor_button pulsed 1 cycle at cycle 2 -> phases 0(8 cycles), 1(3), 2(1), 3(5), 4(3), 7(1), then 0. side=001 exactly during phase 3.
- Pedestrian service: ped_button pulsed at cycle 20 -> phase 0 exits at cycle 20/21 (min green already met), then 1(3), 2(1), 5(6, walk=1), 6(3), 7(1), 0.
- Arbitration: both buttons held high from reset -> SIDE served first. Then 8 cycles of main green, then PED served. Then SIDE again (presses held). Alternation continues with no starvation.
- Timebase: tick asserted every 4th cycle, sensor pulse -> every phase lasts 4x its tick count in cycles. tick held 0 mid-MAIN_YELLOW -> phase frozen.
- Reset mid-operation: reset_button asserted asynchronously mid-SIDE_GREEN -> outputs return to main=001, side=100, phase=0 before the next masterclk edge. Latches are clear afterwards (no service without a new press).
